// File: rtl/ahb_sram_responder.sv
// rtl/ahb_sram_responder.sv - AHB3-Lite scratch SRAM responder with wait states and two-cycle ERROR
// Optional read-data checksum enabled by `define PROTECTED_HRDATA_EN.
module ahb_sram_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE        = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic        s_hwrite_i,
  input  logic [2:0]  s_hsize_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hready_o,
  output logic        s_hresp_o,
  output logic [6:0]  s_hrchecksum_o
);

  localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
  localparam bit          HAS_WAIT    = (WAIT_STATES > 0);
  localparam logic [3:0]  WS_INIT     = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          borrow;
  logic [31:0]   off;
  logic          accept;
  logic          take;
  logic          addr_err;
  logic [3:0]    be;
  logic          we;

  // 33-bit subtract: the borrow flags haddr below BASE without a constant compare
  assign {borrow, off} = {1'b0, s_haddr_i} - {1'b0, BASE};
  assign accept = s_hsel_i & s_htrans_i[1] & s_hready_i;
  assign take   = accept & (state_q != ST_WAIT) & (state_q != ST_ERR1);

  assign addr_err = (s_hsize_i > 3'd2)
                  | ((s_hsize_i == 3'd1) & s_haddr_i[0])
                  | ((s_hsize_i == 3'd2) & (s_haddr_i[1:0] != 2'b00))
                  | borrow
                  | (off[31:2] >= MEM_WORDS_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            state_d = ST_LAST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= off[AW+1:2];
        lane_q  <= s_haddr_i[1:0];
        write_q <= s_hwrite_i;
        size_q  <= s_hsize_i;
      end
    end
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      3'd0:    be = 4'b0001 << lane_q;
      3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Commit happens on the edge that closes LAST, so a following read sees it
  assign we = (state_q == ST_LAST) & write_q;

  always_ff @(posedge s_clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= s_hwdata_i[8*b +: 8];
      end
    end
  end

  assign s_hrdata_o = ((state_q == ST_LAST) && !write_q) ? mem[idx_q] : 32'h0;
  assign s_hready_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign s_hresp_o  = (state_q == ST_ERR1) || (state_q == ST_ERR2);

`ifdef PROTECTED_HRDATA_EN
  always_comb begin
    s_hrchecksum_o = 7'h00;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 6; k++) begin
        if ((((i + 1) >> k) & 1) == 1) s_hrchecksum_o[k] = s_hrchecksum_o[k] ^ s_hrdata_o[i];
      end
    end
    s_hrchecksum_o[6] = ^s_hrdata_o;
  end
`else
  assign s_hrchecksum_o = 7'h00;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_htrans_i[0], off[1:0]};

endmodule
